seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: active-low
// glyphs for hex digits 0-F and the polarity encodings of an/seg/dp.
package seg7_pkg;

   // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   // All segments dark.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Anode and decimal point are active-low as well.
   localparam logic AN_ON   = 1'b0;
   localparam logic AN_OFF  = 1'b1;
   localparam logic DP_ON   = 1'b0;
   localparam logic DP_OFF  = 1'b1;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   // Map each nibble to its glyph; A-F render as A, b, C, d, E, F.
   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scanner. A prescaler holds each digit
// active for REFRESH_DIV clocks; new data is staged in a shadow register and
// only copied to the display register at the frame boundary so a frame is
// never drawn with a mix of old and new digits.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] CNT_MAX  = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow_data;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic                    tc;
   logic                    frame_end;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_en;
   logic                    cur_lz;
   logic                    zero_run;
   logic [6:0]              glyph;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [6:0]              seg_next;
   logic                    dp_next;

   assign tc        = (cnt == CNT_MAX);
   assign frame_end = tc && (idx == IDX_LAST);

   // Prescaler and digit index: the index steps once per terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (tc) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow captures every load; display refreshes only at the frame
   // boundary, taking data_in directly when a load lands on that same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_data <= '0;
         shadow_dp   <= '0;
         disp_data   <= '0;
         disp_dp     <= '0;
      end else begin
         if (load) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
         end
         if (frame_end) begin
            disp_data <= load ? data_in : shadow_data;
            disp_dp   <= load ? dp_in   : shadow_dp;
         end
      end
   end

   // Frame pulse lands in the cycle after the last digit's terminal count.
   always_ff @(posedge clk) begin
      if (rst) frame_done <= 1'b0;
      else     frame_done <= frame_end;
   end

   // Select the active digit and decide whether it is a leading zero,
   // scanning from the most significant digit down.
   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_en   = 1'b0;
      cur_lz   = 1'b0;
      zero_run = 1'b1;
      an_next  = {NUM_DIGITS{AN_OFF}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
         if (idx == i[IW-1:0]) begin
            cur_nib = disp_data[4*i +: 4];
            cur_dp  = disp_dp[i];
            cur_en  = digit_en[i];
            cur_lz  = zero_run && (i != 0);
            if (digit_en[i]) an_next[i] = AN_ON;
         end
      end
   end

   seg7_hex_decode u_decode (
      .nibble (cur_nib),
      .glyph  (glyph)
   );

   // Segment and decimal point for the active digit; disabled digits go dark.
   always_comb begin
      seg_next = SEG_BLANK;
      dp_next  = DP_OFF;
      if (cur_en) begin
         seg_next = (blank_lz && cur_lz) ? SEG_BLANK : glyph;
         dp_next  = cur_dp ? DP_ON : DP_OFF;
      end
   end

   // Registered pin drivers, dark while in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= {NUM_DIGITS{AN_OFF}};
         seg <= SEG_BLANK;
         dp  <= DP_OFF;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (8 digits, 4 clocks per slot) plus a
// single-digit build. Expected per-slot {an,seg,dp} words are queued when
// stimulus is applied and popped as each slot is sampled.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic        load;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   logic [3:0]  data1;
   logic        dp_in1;
   logic        load1;
   logic        en1;
   logic        blz1;
   logic        an1;
   logic [6:0]  seg1;
   logic        dp1;
   logic        fd1;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .load       (load),
      .digit_en   (digit_en),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(1), .REFRESH_DIV(4)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data1),
      .dp_in      (dp_in1),
      .load       (load1),
      .digit_en   (en1),
      .blank_lz   (blz1),
      .an         (an1),
      .seg        (seg1),
      .dp         (dp1),
      .frame_done (fd1)
   );

   function automatic logic [6:0] tb_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Queue the eight expected slot words of one frame.
   function automatic void push_frame(input logic [31:0] d, input logic [7:0] p,
                                      input logic [7:0] en, input logic blz);
      logic [7:0] a;
      logic [6:0] s;
      logic       q;
      logic       allz;
      for (int k = 0; k < 8; k++) begin
         allz = 1'b1;
         for (int j = k; j < 8; j++) if (d[4*j +: 4] != 4'h0) allz = 1'b0;
         if (!en[k]) begin
            a = 8'hFF;
            s = 7'h7F;
            q = 1'b1;
         end else begin
            a = ~(8'h01 << k);
            s = (blz && (k > 0) && allz) ? 7'h7F : tb_glyph(d[4*k +: 4]);
            q = ~p[k];
         end
         exp_q.push_back({a, s, q});
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Step negedges until frame_done is seen (bounded); n = negedges stepped.
   task automatic wait_fd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_done !== 1'b1 && n < 200);
      chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
   endtask

   task automatic wait_fd1(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fd1 !== 1'b1 && n < 50);
      chk("fd1_seen", {31'd0, fd1}, 32'd1);
   endtask

   // Sample each slot of the frame after a boundary; optionally strobe a
   // load while slot ld_slot is active.
   task automatic check_frame(input bit do_wait, input int ld_slot, input logic [31:0] ld_data);
      int          n;
      int          used;
      logic [15:0] e;
      if (do_wait) wait_fd(n);
      used = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) @(posedge clk);
         else repeat (4 - used) @(posedge clk);
         #1;
         used = 0;
         if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d", k), {16'd0, an, seg, dp}, {16'd0, e});
         end
         if (k == ld_slot) begin
            data_in = ld_data;
            load    = 1'b1;
            @(posedge clk);
            #1;
            load = 1'b0;
            used = 1;
         end
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; data_in = '0; dp_in = '0; load = 1'b0;
      digit_en = 8'hFF; blank_lz = 1'b0;
      data1 = 4'h0; dp_in1 = 1'b0; load1 = 1'b0; en1 = 1'b1; blz1 = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_an",  {24'd0, an},  32'hFF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp",  {31'd0, dp},  32'd1);
      chk("rst_fd",  {31'd0, frame_done}, 32'd0);
      chk("rst_an1", {31'd0, an1}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_an",  {24'd0, an},  32'hFE);
      chk("post_rst_seg", {25'd0, seg}, 32'h40);
      chk("post_rst_dp",  {31'd0, dp},  32'd1);

      // Plain hex frame and frame period
      @(negedge clk); data_in = 32'h1234ABCD; load = 1'b1;
      @(negedge clk); load = 1'b0;
      push_frame(32'h1234ABCD, 8'h00, 8'hFF, 1'b0);
      check_frame(1'b1, -1, 32'd0);
      wait_fd(n);
      wait_fd(n);
      chk("period_all_en", n, 32);
      @(negedge clk);
      chk("fd_one_cycle", {31'd0, frame_done}, 32'd0);

      // Leading-zero blanking; blanked digits keep their decimal point
      @(negedge clk); blank_lz = 1'b1; dp_in = 8'h84; data_in = 32'h0000_0050; load = 1'b1;
      @(negedge clk); load = 1'b0;
      push_frame(32'h0000_0050, 8'h84, 8'hFF, 1'b1);
      check_frame(1'b1, -1, 32'd0);

      // Mid-frame load at digit 3 must not tear the current frame
      @(negedge clk); blank_lz = 1'b0; dp_in = 8'h00; data_in = 32'h89AB_CDEF; load = 1'b1;
      @(negedge clk); load = 1'b0;
      push_frame(32'h89AB_CDEF, 8'h00, 8'hFF, 1'b0);
      check_frame(1'b1, 3, 32'h1111_1111);
      push_frame(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
      check_frame(1'b1, -1, 32'd0);

      // Digit enable mask, live; scan period unchanged
      @(negedge clk); digit_en = 8'hAA;
      push_frame(32'h1111_1111, 8'h00, 8'hAA, 1'b0);
      check_frame(1'b1, -1, 32'd0);
      wait_fd(n);
      wait_fd(n);
      chk("period_masked", n, 32);

      // Load coincident with the frame boundary shows in the very next frame
      @(negedge clk); digit_en = 8'hFF;
      wait_fd(n);
      repeat (31) @(negedge clk);
      data_in = 32'h7654_3210; dp_in = 8'h01; load = 1'b1;
      @(negedge clk); load = 1'b0;
      chk("fd_at_bypass", {31'd0, frame_done}, 32'd1);
      push_frame(32'h7654_3210, 8'h01, 8'hFF, 1'b0);
      check_frame(1'b0, -1, 32'd0);

      // Reset during digit 5 with a load that must be ignored
      wait_fd(n);
      repeat (21) @(negedge clk);
      rst = 1'b1; load = 1'b1; data_in = 32'hFFFF_FFFF; dp_in = 8'hFF;
      @(negedge clk); rst = 1'b0; load = 1'b0;
      chk("midrst_an",  {24'd0, an},  32'hFF);
      chk("midrst_seg", {25'd0, seg}, 32'h7F);
      chk("midrst_dp",  {31'd0, dp},  32'd1);
      chk("midrst_fd",  {31'd0, frame_done}, 32'd0);
      @(posedge clk); #1;
      chk("restart_an",  {24'd0, an},  32'hFE);
      chk("restart_seg", {25'd0, seg}, 32'h40);
      wait_fd(n);
      chk("first_fd_after_rst", n, 32);
      push_frame(32'h0, 8'h00, 8'hFF, 1'b0);
      check_frame(1'b0, -1, 32'd0);

      // Single-digit build
      @(negedge clk); data1 = 4'hA; dp_in1 = 1'b1; load1 = 1'b1;
      @(negedge clk); load1 = 1'b0;
      wait_fd1(n);
      @(posedge clk); #1;
      chk("d1_an",  {31'd0, an1},  32'd0);
      chk("d1_seg", {25'd0, seg1}, 32'h08);
      chk("d1_dp",  {31'd0, dp1},  32'd0);
      wait_fd1(n);
      wait_fd1(n);
      chk("d1_period", n, 4);
      @(negedge clk);
      chk("d1_fd_one_cycle", {31'd0, fd1}, 32'd0);
      en1 = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("d1_dis_an",  {31'd0, an1},  32'd1);
      chk("d1_dis_seg", {25'd0, seg1}, 32'h7F);
      chk("d1_dis_dp",  {31'd0, dp1},  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
